calc_controller: RTL and testbench

Sequencer and two-port round-robin arbiter in front of the shared combinational `Calculator` datapath. Two requesters submit an opcode and two operands over valid/ready channels. The controller grants one request at a time, holds the operands stable on the `Calculator` for a configurable settle time, and registers the result. It returns the result to the granted requester with an error flag for illegal requests.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/Calculator.sv | 44 ++++
 rtl/calc_controller.sv | 195 +++++++++++++++++++
 tb/tb_calc_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calc_controller slice.
//   - Opcode constants understood by the Calculator datapath.
//   - OP_LAST marks the highest legal opcode.
//   - calc_state_t: sequencer states.
//   - op_is_illegal(): flags requests that must not reach the datapath.
package calc_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_LAST = OP_DIV;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } calc_state_t;

  // An opcode beyond the datapath's range, or a divide by zero, is answered
  // with an error instead of a computed result.
  function automatic logic op_is_illegal(input logic [3:0] op, input logic b_is_zero);
    return (op > OP_LAST) || ((op == OP_DIV) && b_is_zero);
  endfunction

endpackage

// File: rtl/Calculator.sv
// Calculator: shared combinational unsigned arithmetic datapath.
// Ports:
//   op_select  in  4        opcode (OP_ADD/OP_SUB/OP_MUL/OP_DIV)
//   operand1   in  NBITS    first operand
//   operand2   in  NBITS    second operand
//   resultado  out 2*NBITS  result; SUB wraps modulo 2^(2*NBITS)
module Calculator
  import calc_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic [3:0]         op_select,
  input  logic [NBITS-1:0]   operand1,
  input  logic [NBITS-1:0]   operand2,
  output logic [2*NBITS-1:0] resultado
);

  localparam int RW = 2 * NBITS;

  logic [RW-1:0] w_a;
  logic [RW-1:0] w_b;

  assign w_a = {{NBITS{1'b0}}, operand1};
  assign w_b = {{NBITS{1'b0}}, operand2};

  // Arithmetic select; division by zero yields zero (the controller never uses it)
  always_comb begin
    resultado = {RW{1'b0}};
    case (op_select)
      OP_ADD: resultado = w_a + w_b;
      OP_SUB: resultado = w_a - w_b;
      OP_MUL: resultado = w_a * w_b;
      OP_DIV: begin
        if (w_b != {RW{1'b0}}) begin
          resultado = w_a / w_b;
        end else begin
          resultado = {RW{1'b0}};
        end
      end
      default: resultado = {RW{1'b0}};
    endcase
  end

endmodule

// File: rtl/calc_controller.sv
// calc_controller: two-port round-robin arbiter and sequencer in front of the
// shared Calculator. One request is served at a time; operands are held on the
// datapath for EXEC_CYCLES cycles, then the result is registered and offered
// to the granted port until it is accepted.
// Ports:
//   clock      in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   req_valid  in  2        per-port request valid
//   req_ready  out 2        per-port accept (combinational, IDLE only)
//   req_op     in  8        {op1, op0}
//   req_a      in  2*NBITS  {a1, a0}
//   req_b      in  2*NBITS  {b1, b0}
//   rsp_valid  out 2        one-hot response valid
//   rsp_ready  in  2        per-port response accept
//   rsp_data   out 2*NBITS  result (0 on error)
//   rsp_err    out 1        illegal opcode or divide by zero
//   busy       out 1        high when not IDLE
module calc_controller
  import calc_pkg::*;
#(
  parameter int NBITS       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*NBITS-1:0] req_a,
  input  logic [2*NBITS-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*NBITS-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int         RW       = 2 * NBITS;
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  calc_state_t       r_state;
  calc_state_t       w_state_nxt;
  logic              r_last_grant;
  logic              r_port;
  logic [3:0]        r_op;
  logic [NBITS-1:0]  r_a;
  logic [NBITS-1:0]  r_b;
  logic [3:0]        r_cnt;
  logic [RW-1:0]     r_rsp_data;
  logic              r_rsp_err;
  logic [1:0]        r_rsp_valid;
  logic              r_busy;

  logic              w_grant;
  logic [1:0]        w_req_ready;
  logic              w_accept;
  logic [3:0]        w_sel_op;
  logic [NBITS-1:0]  w_sel_a;
  logic [NBITS-1:0]  w_sel_b;
  logic [RW-1:0]     w_resultado;
  logic [3:0]        w_cnt_nxt;
  logic [RW-1:0]     w_data_nxt;
  logic              w_err_nxt;
  logic              w_port_nxt;
  logic [1:0]        w_valid_nxt;

  // Round robin: a lone requester always wins; on a tie the port not served last wins
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_req_ready = ((r_state == IDLE) && req_valid[w_grant]) ? (2'b01 << w_grant) : 2'b00;
  assign w_accept    = |w_req_ready;
  assign req_ready   = w_req_ready;

  assign w_sel_op = w_grant ? req_op[7:4] : req_op[3:0];
  assign w_sel_a  = w_grant ? req_a[RW-1:NBITS] : req_a[NBITS-1:0];
  assign w_sel_b  = w_grant ? req_b[RW-1:NBITS] : req_b[NBITS-1:0];

  // Latched operands, not the live request bus, feed the datapath so they stay stable in EXEC
  Calculator #(.NBITS(NBITS)) u_calc (
    .op_select (r_op),
    .operand1  (r_a),
    .operand2  (r_b),
    .resultado (w_resultado)
  );

  // Next-state, counter and response values of the sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_rsp_data;
    w_err_nxt   = r_rsp_err;
    w_port_nxt  = r_port;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_port_nxt = w_grant;
          if (op_is_illegal(w_sel_op, (w_sel_b == {NBITS{1'b0}}))) begin
            // Illegal requests skip the datapath entirely
            w_state_nxt = RESP;
            w_data_nxt  = {RW{1'b0}};
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = EXEC;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
          w_data_nxt  = w_resultado;
          w_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        // Only the granted port's acceptance matters
        if (rsp_ready[r_port]) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output flags are precomputed from the next state so they come straight from flops
  always_comb begin
    w_valid_nxt = 2'b00;
    if (w_state_nxt == RESP) begin
      w_valid_nxt = w_port_nxt ? 2'b10 : 2'b01;
    end else begin
      w_valid_nxt = 2'b00;
    end
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, counter and registered response outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_op         <= 4'd0;
      r_a          <= {NBITS{1'b0}};
      r_b          <= {NBITS{1'b0}};
      r_cnt        <= 4'd0;
      r_rsp_data   <= {RW{1'b0}};
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_busy       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_op         <= w_sel_op;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
      end
      r_port      <= w_port_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_data  <= w_data_nxt;
      r_rsp_err   <= w_err_nxt;
      r_rsp_valid <= w_valid_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller. Two instances run side by side:
// dut0 with EXEC_CYCLES=1 and dut1 with EXEC_CYCLES=3. A transaction-level
// model (pending requests, last grant, plain arithmetic) predicts grants,
// latencies and results.
module tb_calc_controller;
  import calc_pkg::*;

  localparam int N  = 4;
  localparam int RW = 2 * N;

  logic            clock;
  logic            rst_n     [2];
  logic [1:0]      req_valid [2];
  logic [1:0]      req_ready [2];
  logic [7:0]      req_op    [2];
  logic [RW-1:0]   req_a     [2];
  logic [RW-1:0]   req_b     [2];
  logic [1:0]      rsp_valid [2];
  logic [1:0]      rsp_ready [2];
  logic [RW-1:0]   rsp_data  [2];
  logic            rsp_err   [2];
  logic            busy      [2];

  int checks;
  int failures;
  int cyc;

  // Model state per instance
  logic [3:0]   m_op   [2][2];
  logic [N-1:0] m_a    [2][2];
  logic [N-1:0] m_b    [2][2];
  logic [1:0]   m_pend [2];
  int           m_last [2];
  int           last_acc [2];

  calc_controller #(.NBITS(N), .EXEC_CYCLES(1)) dut0 (
    .clock(clock), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  calc_controller #(.NBITS(N), .EXEC_CYCLES(3)) dut1 (
    .clock(clock), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ex(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic model_err(input logic [3:0] op, input logic [N-1:0] b);
    return (op > 4'd3) || ((op == 4'd3) && (b == 4'd0));
  endfunction

  function automatic logic [RW-1:0] model_res(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (model_err(op, b)) return 8'h00;
    case (op)
      4'd0:    return RW'(ai + bi);
      4'd1:    return RW'(ai - bi);
      4'd2:    return RW'(ai * bi);
      default: return RW'(ai / bi);
    endcase
  endfunction

  task automatic drive_req(input int d);
    req_valid[d] = m_pend[d];
    req_op[d]    = {m_op[d][1], m_op[d][0]};
    req_a[d]     = {m_a[d][1], m_a[d][0]};
    req_b[d]     = {m_b[d][1], m_b[d][0]};
  endtask

  task automatic set_req(input int d, input int p, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    m_op[d][p]   = op;
    m_a[d][p]    = a;
    m_b[d][p]    = b;
    m_pend[d][p] = 1'b1;
  endtask

  // Serve exactly one grant from the pending set; DUT must be in IDLE on entry
  task automatic serve(input int d, input int hold, input string tag);
    int g;
    int lat;
    int exp_lat;
    logic [3:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [RW-1:0] exp_d;
    logic          exp_e;
    logic [1:0]    oh;
    logic [1:0]    oth;
    logic [3:0]    so;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    g       = (m_pend[d] == 2'b11) ? (1 - m_last[d]) : (m_pend[d][1] ? 1 : 0);
    oh      = (g == 1) ? 2'b10 : 2'b01;
    oth     = ~oh;
    op      = m_op[d][g];
    a       = m_a[d][g];
    b       = m_b[d][g];
    exp_d   = model_res(op, a, b);
    exp_e   = model_err(op, b);
    exp_lat = exp_e ? 1 : ex(d) + 1;

    @(negedge clock);
    drive_req(d);
    rsp_ready[d] = 2'b00;
    #1;
    checks++;
    if (busy[d] !== 1'b0 || rsp_valid[d] !== 2'b00) begin
      failures++;
      $display("FAIL %s idle: busy=%b rsp_valid=%b expected busy=0 rsp_valid=00", tag, busy[d], rsp_valid[d]);
    end
    checks++;
    if (req_ready[d] !== oh) begin
      failures++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready[d], oh);
    end
    last_acc[d]  = cyc + 1;
    m_last[d]    = g;
    m_pend[d][g] = 1'b0;

    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      drive_req(d);
      rsp_ready[d] = (hold == 0) ? 2'b11 : oth;
      #1;
      if (rsp_valid[d] !== 2'b00) begin
        lat = j;
        break;
      end
      checks++;
      if (busy[d] !== 1'b1 || req_ready[d] !== 2'b00) begin
        failures++;
        $display("FAIL %s exec: busy=%b req_ready=%b expected busy=1 req_ready=00", tag, busy[d], req_ready[d]);
      end
      if (d == 0) begin
        so = dut0.u_calc.op_select; sa = dut0.u_calc.operand1; sb = dut0.u_calc.operand2;
      end else begin
        so = dut1.u_calc.op_select; sa = dut1.u_calc.operand1; sb = dut1.u_calc.operand2;
      end
      checks++;
      if (so !== op || sa !== a || sb !== b) begin
        failures++;
        $display("FAIL %s operands: calc=%h/%h/%h expected %h/%h/%h", tag, so, sa, sb, op, a, b);
      end
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles expected %0d (0 = none within bound)", tag, lat, exp_lat);
    end
    checks++;
    if (rsp_valid[d] !== oh || rsp_data[d] !== exp_d || rsp_err[d] !== exp_e) begin
      failures++;
      $display("FAIL %s response: valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
               tag, rsp_valid[d], rsp_data[d], rsp_err[d], oh, exp_d, exp_e);
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge clock);
      drive_req(d);
      rsp_ready[d] = oth;
      #1;
      checks++;
      if (rsp_valid[d] !== oh || rsp_data[d] !== exp_d || rsp_err[d] !== exp_e ||
          busy[d] !== 1'b1 || req_ready[d] !== 2'b00) begin
        failures++;
        $display("FAIL %s hold: valid=%b data=%h err=%b busy=%b req_ready=%b expected valid=%b data=%h err=%b busy=1 req_ready=00",
                 tag, rsp_valid[d], rsp_data[d], rsp_err[d], busy[d], req_ready[d], oh, exp_d, exp_e);
      end
    end
    if (hold > 0) begin
      @(negedge clock);
      drive_req(d);
      rsp_ready[d] = oh | (oth & 2'($urandom_range(0, 3)));
      #1;
      checks++;
      if (rsp_valid[d] !== oh || rsp_data[d] !== exp_d) begin
        failures++;
        $display("FAIL %s release: valid=%b data=%h expected valid=%b data=%h", tag, rsp_valid[d], rsp_data[d], oh, exp_d);
      end
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 2'b00; rsp_ready[d] = 2'b00;
      req_op[d] = 8'h00; req_a[d] = 8'h00; req_b[d] = 8'h00;
      m_pend[d] = 2'b00; m_last[d] = 1; last_acc[d] = 0;
      for (int p = 0; p < 2; p++) begin
        m_op[d][p] = 4'd0; m_a[d][p] = 4'd0; m_b[d][p] = 4'd0;
      end
    end
    repeat (2) @(negedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_valid[d] !== 2'b00 || rsp_data[d] !== 8'h00 || rsp_err[d] !== 1'b0 || busy[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: valid=%b data=%h err=%b busy=%b expected all zero",
                 d, rsp_valid[d], rsp_data[d], rsp_err[d], busy[d]);
      end
    end
    @(negedge clock);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
  endtask

  task automatic test_add;
    set_req(0, 0, OP_ADD, 4'd1, 4'd1);
    serve(0, 0, "add");
  endtask

  task automatic test_tie;
    set_req(0, 0, OP_SUB, 4'd3, 4'd1);
    set_req(0, 1, OP_MUL, 4'd3, 4'd3);
    serve(0, 0, "tie_first");
    serve(0, 0, "tie_second");
    set_req(0, 0, OP_ADD, 4'd7, 4'd2);
    set_req(0, 1, OP_ADD, 4'd9, 4'd9);
    serve(0, 1, "tie_next_first");
    serve(0, 1, "tie_next_second");
  endtask

  task automatic test_illegal;
    set_req(0, 1, OP_DIV, 4'd6, 4'd0);
    serve(0, 0, "div_zero");
    set_req(0, 1, 4'b1010, 4'd5, 4'd3);
    serve(0, 2, "bad_opcode");
    set_req(1, 0, 4'b0100, 4'd1, 4'd1);
    serve(1, 0, "bad_opcode_e3");
  endtask

  task automatic test_exec3;
    set_req(1, 0, OP_MUL, 4'd15, 4'd15);
    serve(1, 0, "mul_e3");
    set_req(1, 1, OP_SUB, 4'd2, 4'd9);
    serve(1, 0, "sub_wrap_e3");
  endtask

  task automatic test_hold;
    set_req(1, 1, OP_DIV, 4'd13, 4'd4);
    serve(1, 5, "hold5");
  endtask

  task automatic test_back_to_back;
    int prev;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, OP_ADD, 4'd4, 4'd5);
      serve(d, 0, "b2b_first");
      for (int k = 0; k < 3; k++) begin
        prev = last_acc[d];
        set_req(d, 0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        serve(d, 0, "b2b");
        checks++;
        if (last_acc[d] - prev != ex(d) + 2) begin
          failures++;
          $display("FAIL b2b spacing dut%0d: %0d cycles expected %0d", d, last_acc[d] - prev, ex(d) + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    set_req(1, 0, OP_MUL, 4'd5, 4'd7);
    @(negedge clock);
    drive_req(1);
    rsp_ready[1] = 2'b11;
    #1;
    checks++;
    if (req_ready[1] !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid accept: req_ready=%b expected 01", req_ready[1]);
    end
    m_pend[1] = 2'b00;
    @(negedge clock);
    drive_req(1);
    #1;
    checks++;
    if (busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid exec: busy=%b expected 1", busy[1]);
    end
    #2;
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 2'b00 || rsp_data[1] !== 8'h00 || rsp_err[1] !== 1'b0 || busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async: valid=%b data=%h err=%b busy=%b expected all zero",
               rsp_valid[1], rsp_data[1], rsp_err[1], busy[1]);
    end
    @(negedge clock);
    rst_n[1]  = 1'b1;
    m_last[1] = 1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      #1;
      checks++;
      if (rsp_valid[1] !== 2'b00 || busy[1] !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid dropped: valid=%b busy=%b expected 00/0", rsp_valid[1], busy[1]);
      end
    end
    rsp_ready[1] = 2'b00;
    // After reset the first tie must go to port 0 again
    set_req(1, 0, OP_ADD, 4'd15, 4'd15);
    set_req(1, 1, OP_ADD, 4'd1, 4'd2);
    serve(1, 0, "post_rst_tie0");
    serve(1, 0, "post_rst_tie1");
  endtask

  task automatic test_random;
    logic [1:0] pat;
    logic [N-1:0] b;
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 14; it++) begin
        pat = 2'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++) begin
          if (pat[p] && !m_pend[d][p]) begin
            b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            set_req(d, p, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), b);
          end
        end
        serve(d, $urandom_range(0, 2), "random");
      end
      for (int k = 0; k < 2; k++) begin
        if (m_pend[d] != 2'b00) serve(d, 0, "random_drain");
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_add();
    test_tie();
    test_illegal();
    test_exec3();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
